// File: rtl/envelope_sequencer.sv
// envelope_sequencer: per-note ADSR gain sequencer with a two-stage gain multiply.
// The gain moves one step per in_ready strobe through Idle/Attack/Decay/Sustain/Release.
// Each incoming sample is scaled by the gain held before that strobe's step.
module envelope_sequencer #(
    parameter logic [15:0] GAIN_MAX = 16'hFFFF,
    parameter int          LATENCY  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        note_on,
    input  logic        note_off,
    input  logic [15:0] attack_rate,
    input  logic [15:0] decay_rate,
    input  logic [15:0] sustain_level,
    input  logic [15:0] release_rate,
    input  logic [15:0] sample_in,
    input  logic        in_ready,
    output logic [15:0] sample_out,
    output logic        out_valid,
    output logic [15:0] gain,
    output logic [2:0]  env_state,
    output logic        active
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ATTACK  = 3'd1;
    localparam logic [2:0] DECAY   = 3'd2;
    localparam logic [2:0] SUSTAIN = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [15:0]        gain_q, gain_d;
    logic [15:0]        att_q, att_d;
    logic [15:0]        dec_q, dec_d;
    logic [15:0]        sus_q, sus_d;
    logic [15:0]        rel_q, rel_d;
    logic signed [32:0] prod_p1_q, prod_p1_d;
    logic signed [15:0] out_p2_q, out_p2_d;
    logic [LATENCY-1:0] vld_q, vld_d;

    // Attack step: 17-bit sum clipped at the peak; a zero rate jumps straight to the peak.
    function automatic logic [15:0] sat_add(input logic [15:0] g, input logic [15:0] a);
        logic [16:0] s;
        s = {1'b0, g} + {1'b0, a};
        if (a == 16'd0 || s >= {1'b0, GAIN_MAX})
            return GAIN_MAX;
        return s[15:0];
    endfunction

    // Decay/release step: max(g - d, floor); a zero rate jumps straight to the floor.
    function automatic logic [15:0] floor_sub(input logic [15:0] g, input logic [15:0] d,
                                              input logic [15:0] floor_v);
        if (d == 16'd0 || g <= floor_v || (g - floor_v) <= d)
            return floor_v;
        return g - d;
    endfunction

    // Signed sample times unsigned Q0.16 gain, carried as 33-bit signed.
    function automatic logic signed [32:0] mul_gain(input logic signed [15:0] s,
                                                    input logic [15:0] g);
        logic signed [32:0] se;
        logic signed [32:0] ge;
        se = {{17{s[15]}}, s};
        ge = {17'd0, g};
        return se * ge;
    endfunction

    // Drop the Q0.16 fraction; arithmetic shift floors toward minus infinity.
    function automatic logic signed [15:0] trunc_q16(input logic signed [32:0] p);
        return 16'(p >>> 16);
    endfunction

    // Envelope control: note events take priority and suppress that cycle's gain step.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        att_d   = att_q;
        dec_d   = dec_q;
        sus_d   = sus_q;
        rel_d   = rel_q;
        if (note_on) begin
            state_d = ATTACK;
            att_d   = attack_rate;
            dec_d   = decay_rate;
            sus_d   = sustain_level;
        end else if (note_off && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
            state_d = RELEASE;
            rel_d   = release_rate;
        end else if (in_ready) begin
            case (state_q)
                ATTACK: begin
                    gain_d = sat_add(gain_q, att_q);
                    if (gain_d == GAIN_MAX)
                        state_d = DECAY;
                end
                DECAY: begin
                    gain_d = floor_sub(gain_q, dec_q, sus_q);
                    if (gain_d == sus_q)
                        state_d = SUSTAIN;
                end
                RELEASE: begin
                    gain_d = floor_sub(gain_q, rel_q, 16'd0);
                    if (gain_d == 16'd0)
                        state_d = IDLE;
                end
                default: begin
                    gain_d = gain_q;
                end
            endcase
        end
    end

    // Multiply pipeline: stage 1 forms the product, stage 2 truncates to the output sample.
    always_comb begin
        prod_p1_d = prod_p1_q;
        out_p2_d  = out_p2_q;
        vld_d     = {vld_q[LATENCY-2:0], in_ready};
        if (in_ready)
            prod_p1_d = mul_gain(sample_in, gain_q);
        if (vld_q[0])
            out_p2_d = trunc_q16(prod_p1_q);
    end

    // State, latched rates and pipeline registers; reset clears everything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            gain_q    <= 16'd0;
            att_q     <= 16'd0;
            dec_q     <= 16'd0;
            sus_q     <= 16'd0;
            rel_q     <= 16'd0;
            prod_p1_q <= '0;
            out_p2_q  <= '0;
            vld_q     <= '0;
        end else begin
            state_q   <= state_d;
            gain_q    <= gain_d;
            att_q     <= att_d;
            dec_q     <= dec_d;
            sus_q     <= sus_d;
            rel_q     <= rel_d;
            prod_p1_q <= prod_p1_d;
            out_p2_q  <= out_p2_d;
            vld_q     <= vld_d;
        end
    end

    assign sample_out = out_p2_q;
    assign out_valid  = vld_q[LATENCY-1];
    assign gain       = gain_q;
    assign env_state  = state_q;
    assign active     = (state_q != IDLE);

endmodule

// File: tb/tb_envelope_sequencer.sv
// Testbench for envelope_sequencer: directed ADSR scenarios followed by random
// note/strobe traffic, all checked against an arithmetic reference model.
module tb_envelope_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        note_on, note_off, in_ready;
    logic [15:0] attack_rate, decay_rate, sustain_level, release_rate, sample_in;
    logic [15:0] sample_out, gain;
    logic        out_valid, active;
    logic [2:0]  env_state;

    envelope_sequencer dut (
        .clk(clk), .reset(reset), .note_on(note_on), .note_off(note_off),
        .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_level(sustain_level), .release_rate(release_rate),
        .sample_in(sample_in), .in_ready(in_ready), .sample_out(sample_out),
        .out_valid(out_valid), .gain(gain), .env_state(env_state), .active(active)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: phase number, gain and latched rates as plain integers.
    int m_st, m_g, m_att, m_dec, m_sus, m_rel;
    typedef struct { int due; logic [15:0] val; } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_g = 0; m_att = 0; m_dec = 0; m_sus = 0; m_rel = 0;
        exp_q.delete();
    endtask

    // One clock edge of the envelope rules, using the inputs currently driven.
    task automatic model_edge();
        longint p;
        int t;
        if (in_ready) begin
            p = longint'($signed(sample_in)) * longint'(m_g);
            exp_q.push_back('{due: cyc + 2, val: 16'(p >>> 16)});
        end
        if (note_on) begin
            m_st = 1; m_att = attack_rate; m_dec = decay_rate; m_sus = sustain_level;
        end else if (note_off && m_st >= 1 && m_st <= 3) begin
            m_st = 4; m_rel = release_rate;
        end else if (in_ready) begin
            if (m_st == 1) begin
                if (m_att == 0) m_g = 65535;
                else begin t = m_g + m_att; m_g = (t < 65535) ? t : 65535; end
                if (m_g == 65535) m_st = 2;
            end else if (m_st == 2) begin
                if (m_dec == 0) m_g = m_sus;
                else begin t = m_g - m_dec; m_g = (t > m_sus) ? t : m_sus; end
                if (m_g == m_sus) m_st = 3;
            end else if (m_st == 4) begin
                if (m_rel == 0) m_g = 0;
                else begin t = m_g - m_rel; m_g = (t > 0) ? t : 0; end
                if (m_g == 0) m_st = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("gain", gain, m_g);
        chk("env_state", env_state, m_st);
        chk("active", active, (m_st != 0));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("out_valid", out_valid, 1);
            chk("sample_out", sample_out, exp_q[0].val);
            void'(exp_q.pop_front());
        end else begin
            chk("out_valid_idle", out_valid, 0);
        end
    endtask

    // Advance one clock with the inputs as driven, then clear the pulses.
    task automatic step();
        if (reset) model_edge();
        @(posedge clk); #1;
        cyc++;
        check_all();
        note_on = 1'b0; note_off = 1'b0; in_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic strobe(input logic [15:0] s);
        in_ready = 1'b1; sample_in = s;
        step();
    endtask

    task automatic async_reset();
        #3 reset = 1'b0;
        model_reset();
        #1;
        chk("rst_gain", gain, 0);
        chk("rst_state", env_state, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sample_out", sample_out, 0);
        chk("rst_active", active, 0);
    endtask

    function automatic logic [15:0] rnd_rate();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'($urandom_range(16'h0800, 16'h4000));
            2:       return 16'($urandom);
            default: return 16'hFFFF;
        endcase
    endfunction

    logic [15:0] att_seq [4];
    logic [15:0] dec_seq [4];
    logic [15:0] rel_seq [3];

    initial begin
        att_seq = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        dec_seq = '{16'hDFFF, 16'hBFFF, 16'h9FFF, 16'h8000};
        rel_seq = '{16'h5000, 16'h2000, 16'h0000};
        reset = 1'b0; note_on = 0; note_off = 0; in_ready = 0; sample_in = 0;
        attack_rate = 0; decay_rate = 0; sustain_level = 0; release_rate = 0;
        model_reset();
        @(posedge clk); #1;

        // Reset held with traffic, then a reset mid-note with samples in flight.
        in_ready = 1; idle(1); in_ready = 0; idle(1);
        reset = 1'b1;
        attack_rate = 16'h4000; decay_rate = 16'h2000; sustain_level = 16'h8000;
        note_on = 1; step();
        strobe(16'h1234);
        strobe(16'h4000);
        async_reset();
        in_ready = 1; step(); step(); in_ready = 1; step();
        reset = 1'b1;
        idle(2);
        strobe(16'h7000);
        chk("post_rst_no_valid", out_valid, 0);
        step();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_zero", sample_out, 0);

        // Attack / decay / sustain with one strobe every 8 cycles.
        attack_rate = 16'h4000; decay_rate = 16'h2000; sustain_level = 16'h8000;
        note_on = 1; step();
        chk("note_on_attack", env_state, 1);
        for (int i = 0; i < 4; i++) begin
            strobe(16'($urandom));
            chk("attack_gain", gain, att_seq[i]);
            idle(7);
        end
        chk("to_decay", env_state, 2);
        for (int i = 0; i < 4; i++) begin
            strobe(16'($urandom));
            chk("decay_gain", gain, dec_seq[i]);
            idle(7);
        end
        chk("to_sustain", env_state, 3);
        sustain_level = 16'h1000;
        strobe(16'h0100); idle(7);
        chk("sustain_hold", gain, 16'h8000);
        chk("sustain_state", env_state, 3);

        // Release to idle.
        release_rate = 16'h3000; note_off = 1; step();
        chk("note_off_release", env_state, 4);
        for (int i = 0; i < 3; i++) begin
            strobe(16'($urandom));
            chk("release_gain", gain, rel_seq[i]);
            idle(7);
        end
        chk("release_idle", env_state, 0);
        chk("release_inactive", active, 0);

        // Retrigger from release with note_on + note_off + in_ready together.
        attack_rate = 16'h4000; decay_rate = 16'h1000; sustain_level = 16'h8000;
        note_on = 1; step();
        strobe(16'h2222);
        release_rate = 16'h2000; note_off = 1; step();
        strobe(16'h3333);
        chk("rel_at_2000", gain, 16'h2000);
        chk("rel_state", env_state, 4);
        note_on = 1; note_off = 1; in_ready = 1; sample_in = 16'h5555; step();
        chk("retrig_state", env_state, 1);
        chk("retrig_gain_hold", gain, 16'h2000);
        strobe(16'h0000);
        chk("retrig_rise", gain, 16'h6000);

        // Zero attack rate, full-scale products, back-to-back strobes, zero release rate.
        attack_rate = 16'h0000; decay_rate = 16'h0100; sustain_level = 16'hFFFF;
        note_on = 1; step();
        strobe(16'h0001);
        chk("att0_gain", gain, 16'hFFFF);
        chk("att0_decay", env_state, 2);
        strobe(16'h0001);
        chk("sus_max_state", env_state, 3);
        idle(3);
        in_ready = 1; sample_in = 16'h7FFF; step();
        in_ready = 1; sample_in = 16'h8000; step();
        chk("b2b_valid0", out_valid, 1);
        chk("b2b_pos", sample_out, 16'h7FFE);
        step();
        chk("b2b_valid1", out_valid, 1);
        chk("b2b_neg", sample_out, 16'h8000);
        step();
        chk("b2b_end", out_valid, 0);
        release_rate = 16'h0000; note_off = 1; step();
        strobe(16'h1111);
        chk("rel0_gain", gain, 16'h0000);
        chk("rel0_idle", env_state, 0);
        idle(3);

        // Random traffic with one mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                async_reset();
                in_ready = 1; step(); step();
                reset = 1'b1;
            end
            attack_rate   = rnd_rate();
            decay_rate    = rnd_rate();
            release_rate  = rnd_rate();
            sustain_level = 16'($urandom);
            sample_in     = 16'($urandom);
            note_on       = ($urandom_range(0, 39) == 0);
            note_off      = ($urandom_range(0, 24) == 0);
            in_ready      = 1'($urandom_range(0, 1));
            step();
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
